// File: rtl/kmeans_pkg.sv
// Shared types for the k-means core: RAM geometry, arbiter FSM
// states and requester identities.
package kmeans_pkg;

  localparam int RAM_ADDR_W = 9;
  localparam int RAM_DATA_W = 91;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } arb_state_t;

  typedef enum logic {
    HOST = 1'b0,
    CORE = 1'b1
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that
// did not win last time is chosen.
module rr_arb2
  import kmeans_pkg::*;
(
  input  logic host_el,
  input  logic core_el,
  input  req_t last,
  output req_t win,
  output logic valid
);

  always_comb begin
    valid = host_el | core_el;
    win   = CORE;
    unique case (1'b1)
      (host_el && core_el):  win = (last == CORE) ? HOST : CORE;
      (host_el && !core_el): win = HOST;
      default:               win = CORE;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between host writes and core reads.
// All outputs are registered; a read returns data two cycles after c_gnt.
module ram_arbiter
  import kmeans_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_req,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              host_lock,
  output logic              h_gnt,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);

  arb_state_t state;
  req_t       last;
  req_t       win;
  logic       win_vld;
  logic       host_el;

  assign host_el = h_req & ~host_lock;

  rr_arb2 u_rr (
    .host_el (host_el),
    .core_el (c_req),
    .last    (last),
    .win     (win),
    .valid   (win_vld)
  );

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Strobes and pulses default inactive each cycle; only a grant
  // in IDLE sets them up for the single following access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= CORE;
      ram_cs_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      c_rdata   <= '0;
      h_gnt     <= 1'b0;
      c_gnt     <= 1'b0;
      c_rvalid  <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
    end else begin
      ram_cs_n <= 1'b1;
      ram_we_n <= 1'b1;
      ram_oe_n <= 1'b1;
      h_gnt    <= 1'b0;
      c_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            last     <= win;
            ram_cs_n <= 1'b0;
            if (win == HOST) begin
              state     <= WRITE;
              ram_we_n  <= 1'b0;
              ram_addr  <= h_addr;
              ram_wdata <= h_wdata;
              h_gnt     <= 1'b1;
              wr_cnt    <= sat_inc(wr_cnt);
            end else begin
              state    <= READ;
              ram_oe_n <= 1'b0;
              ram_addr <= c_addr;
              c_gnt    <= 1'b1;
              rd_cnt   <= sat_inc(rd_cnt);
            end
          end
        end
        WRITE: state <= IDLE;
        READ:  state <= CAPTURE;
        CAPTURE: begin
          c_rdata  <= ram_rdata;
          c_rvalid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: cycle vector table plus
// hand-written write, read, reset-abort and saturation sequences.
module tb_ram_arbiter;

  localparam int AW = 9;
  localparam int DW = 91;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          h_req, host_lock, c_req;
  logic [AW-1:0] h_addr, c_addr;
  logic [DW-1:0] h_wdata;
  logic [DW-1:0] ram_rdata;

  logic          h_gnt, c_gnt, c_rvalid;
  logic [DW-1:0] c_rdata, ram_wdata;
  logic          ram_cs_n, ram_we_n, ram_oe_n;
  logic [AW-1:0] ram_addr;
  logic [15:0]   wr_cnt, rd_cnt;

  logic          h_gnt2, c_gnt2, c_rvalid2;
  logic [DW-1:0] c_rdata2, ram_wdata2;
  logic          ram_cs_n2, ram_we_n2, ram_oe_n2;
  logic [AW-1:0] ram_addr2;
  logic [1:0]    wr_cnt2, rd_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_addr(h_addr), .h_wdata(h_wdata),
    .host_lock(host_lock), .h_gnt(h_gnt),
    .c_req(c_req), .c_addr(c_addr), .c_gnt(c_gnt),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  ram_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .h_req(h_req), .h_addr(h_addr), .h_wdata(h_wdata),
    .host_lock(host_lock), .h_gnt(h_gnt2),
    .c_req(c_req), .c_addr(c_addr), .c_gnt(c_gnt2),
    .c_rvalid(c_rvalid2), .c_rdata(c_rdata2),
    .ram_cs_n(ram_cs_n2), .ram_we_n(ram_we_n2), .ram_oe_n(ram_oe_n2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata),
    .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2)
  );

  // RAM model: read data appears the cycle after the read strobe
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    mem[9'h010] = 91'hABC;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (!ram_cs_n && !ram_oe_n) ram_rdata <= mem[ram_addr];
    if (!ram_cs_n && !ram_we_n) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    h_req = 0; c_req = 0; host_lock = 0;
    h_addr = '0; c_addr = '0; h_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic h_req, c_req, lock;
    logic e_hg, e_cg, e_rv;
  } vec_t;

  function automatic vec_t mk(input logic hr, cr, lk, hg, cg, rv);
    vec_t v;
    v.h_req = hr; v.c_req = cr; v.lock = lk;
    v.e_hg = hg; v.e_cg = cg; v.e_rv = rv;
    return v;
  endfunction

  vec_t vt [0:28];
  bit seen;

  initial begin
    // alternation H,C,... from reset: period 5 cycles
    for (int i = 0; i < 20; i++) begin
      vt[i] = mk(1, 1, 0, (i % 5) == 0, (i % 5) == 2, (i % 5) == 4);
    end
    vt[20] = mk(1, 1, 1, 0, 1, 0);
    vt[21] = mk(1, 1, 1, 0, 0, 0);
    vt[22] = mk(1, 1, 1, 0, 0, 1);
    vt[23] = mk(1, 1, 1, 0, 1, 0);
    vt[24] = mk(1, 1, 1, 0, 0, 0);
    vt[25] = mk(1, 1, 1, 0, 0, 1);
    vt[26] = mk(1, 1, 0, 1, 0, 0);
    vt[27] = mk(1, 1, 1, 0, 0, 0);
    vt[28] = mk(0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    h_req = 0; c_req = 0; host_lock = 0;
    h_addr = '0; c_addr = '0; h_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", 96'(ram_cs_n), 96'd1);
    chk("rst_we_n", 96'(ram_we_n), 96'd1);
    chk("rst_oe_n", 96'(ram_oe_n), 96'd1);
    chk("rst_gnts", 96'({h_gnt, c_gnt, c_rvalid}), 96'd0);
    chk("rst_addr", 96'(ram_addr), 96'd0);
    chk("rst_cnts", 96'({wr_cnt, rd_cnt}), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single host write
    @(negedge clk);
    h_req = 1; h_addr = 9'h005; h_wdata = 91'h1234;
    @(posedge clk); #1;
    chk("wr_h_gnt", 96'(h_gnt), 96'd1);
    chk("wr_strobes", 96'({ram_cs_n, ram_we_n, ram_oe_n}), 96'b001);
    chk("wr_addr", 96'(ram_addr), 96'h005);
    chk("wr_wdata", 96'(ram_wdata), 96'h1234);
    chk("wr_cnt1", 96'(wr_cnt), 96'd1);
    @(negedge clk);
    h_req = 0;
    @(posedge clk); #1;
    chk("wr_end", 96'({h_gnt, ram_cs_n}), 96'b01);

    // core read of 0x010
    @(negedge clk);
    c_req = 1; c_addr = 9'h010;
    @(posedge clk); #1;
    chk("rd_c_gnt_t1", 96'(c_gnt), 96'd1);
    chk("rd_strobes", 96'({ram_cs_n, ram_we_n, ram_oe_n}), 96'b010);
    chk("rd_addr", 96'(ram_addr), 96'h010);
    @(negedge clk);
    c_req = 0;
    @(posedge clk); #1;
    chk("rd_rvalid_t2", 96'({c_gnt, c_rvalid}), 96'd0);
    @(posedge clk); #1;
    chk("rd_rvalid_t3", 96'(c_rvalid), 96'd1);
    chk("rd_rdata", 96'(c_rdata), 96'hABC);
    chk("rd_cnt1", 96'(rd_cnt), 96'd1);
    @(posedge clk); #1;
    chk("rd_rvalid_off", 96'(c_rvalid), 96'd0);
    chk("rd_rdata_hold", 96'(c_rdata), 96'hABC);

    // contention and host_lock table
    do_reset();
    h_addr = 9'h020; c_addr = 9'h010; h_wdata = 91'h55;
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      h_req = vt[i].h_req; c_req = vt[i].c_req;
      host_lock = vt[i].lock;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_gnt", i),
          96'({h_gnt, c_gnt, c_rvalid}),
          96'({vt[i].e_hg, vt[i].e_cg, vt[i].e_rv}));
      chk($sformatf("vec%0d_cs_n", i), 96'(ram_cs_n),
          96'(!(vt[i].e_hg || vt[i].e_cg)));
    end
    chk("vec_wr_cnt", 96'(wr_cnt), 96'd5);
    chk("vec_rd_cnt", 96'(rd_cnt), 96'd6);

    // reset asserted during READ aborts the access
    do_reset();
    @(negedge clk);
    c_req = 1; c_addr = 9'h010;
    @(posedge clk); #1;
    chk("abort_in_read", 96'({c_gnt, ram_oe_n}), 96'b10);
    #1;
    rst_n = 1'b0;
    c_req = 0;
    #1;
    chk("abort_strobes", 96'({ram_cs_n, ram_we_n, ram_oe_n}), 96'b111);
    chk("abort_gnt", 96'(c_gnt), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (c_rvalid) seen = 1;
    end
    chk("abort_no_rvalid", 96'(seen), 96'd0);

    // counter saturation with CNT_W=2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      h_req = 1; h_addr = 9'(i); h_wdata = 91'(i + 1);
      @(negedge clk);
      h_req = 0;
    end
    @(posedge clk); #1;
    chk("sat_wr_cnt2", 96'(wr_cnt2), 96'd3);
    chk("sat_wr_cnt16", 96'(wr_cnt), 96'd5);
    chk("sat_rd_cnt2", 96'(rd_cnt2), 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
